// File: rtl/joint_pwm_ramp_ctrl.sv
// Per-joint duty sequencer: once per PWM period, sweeps all joints and slews each
// registered duty toward its commanded target, with command watchdog and global enable.
module joint_pwm_ramp_ctrl #(
  parameter int JOINTS     = 4,
  parameter int PWM_PERIOD = 100000,
  parameter int RAMP_STEP  = 100,
  parameter int WDT_CYCLES = 5000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [3:0]           cmd_joint,
  input  logic [31:0]          cmd_value,
  output logic [32*JOINTS-1:0] duty_cmd,
  output logic                 period_tick,
  output logic                 busy,
  output logic                 fault
);

  localparam int CNT_W = $clog2(PWM_PERIOD + 1);
  localparam int WDT_W = $clog2(WDT_CYCLES + 1);

  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(PWM_PERIOD - 1);
  localparam logic [WDT_W-1:0]  WDT_LAST = WDT_W'(WDT_CYCLES - 1);
  localparam logic [3:0]        LAST_IDX = 4'(JOINTS - 1);
  localparam logic [4:0]        N_JOINT  = 5'(JOINTS);
  localparam logic signed [32:0] LIM     = 33'(PWM_PERIOD);
  localparam logic signed [32:0] STEP    = 33'(RAMP_STEP);

  typedef enum logic {IDLE, UPDATE} state_e;

  // Saturate a signed 32-bit target to +/-PWM_PERIOD.
  function automatic logic [31:0] clamp_duty(input logic [31:0] v);
    logic signed [32:0] w;
    w = $signed({v[31], v});
    if (w > LIM)       w = LIM;
    else if (w < -LIM) w = -LIM;
    return w[31:0];
  endfunction

  // One slew step. Opposite-signed target first drains the duty to exactly zero,
  // so a reversal always parks at zero for at least one period.
  function automatic logic [31:0] ramp_duty(input logic [31:0] cur, input logic [31:0] tgt);
    logic signed [32:0] c, t, d, r;
    logic c_pos, c_neg, t_pos, t_neg;
    c     = $signed({cur[31], cur});
    t     = $signed({tgt[31], tgt});
    d     = t - c;
    c_neg = c[32];
    t_neg = t[32];
    c_pos = !c[32] && (c != 33'sd0);
    t_pos = !t[32] && (t != 33'sd0);
    if ((c_pos && t_neg) || (c_neg && t_pos)) begin
      if (c > STEP)       r = c - STEP;
      else if (c < -STEP) r = c + STEP;
      else                r = 33'sd0;
    end else begin
      if (d > STEP)       r = c + STEP;
      else if (d < -STEP) r = c - STEP;
      else                r = t;
    end
    return r[31:0];
  endfunction

  state_e           state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic [WDT_W-1:0] wdt_q, wdt_d;
  logic             fault_q, fault_d;
  logic [31:0]      tgt_q [JOINTS];
  logic [31:0]      tgt_d [JOINTS];
  logic [31:0]      duty_q [JOINTS];
  logic [31:0]      duty_d [JOINTS];

  logic             accept, joint_ok, upd_en;
  logic [3:0]       upd_j;
  logic [31:0]      cmd_clamped;

  assign cmd_ready   = (state_q == IDLE) && enable && !fault_q;
  assign busy        = (state_q == UPDATE);
  assign period_tick = tick_q;
  assign fault       = fault_q;
  assign accept      = cmd_valid && cmd_ready;
  assign joint_ok    = ({1'b0, cmd_joint} < N_JOINT);
  assign cmd_clamped = clamp_duty(cmd_value);

  for (genvar g = 0; g < JOINTS; g++) begin : g_pack
    assign duty_cmd[32*g +: 32] = duty_q[g];
  end

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    cnt_d   = (cnt_q == LAST_CNT) ? '0 : cnt_q + CNT_W'(1);
    tick_d  = (cnt_d == LAST_CNT);
    state_d = state_q;
    idx_d   = idx_q;
    upd_en  = 1'b0;
    upd_j   = idx_q + 4'd1;
    tgt_d   = tgt_q;
    duty_d  = duty_q;
    wdt_d   = wdt_q;
    fault_d = fault_q;

    for (int j = 0; j < JOINTS; j++)
      if (accept && cmd_joint == 4'(j)) tgt_d[j] = cmd_clamped;

    // The write for joint idx lands on the edge entering that slot, so joint 0 is
    // handled on the tick cycle itself, using a target accepted in that same cycle.
    case (state_q)
      IDLE: begin
        if (tick_q) begin
          state_d = UPDATE;
          idx_d   = '0;
          upd_en  = 1'b1;
          upd_j   = '0;
        end
      end
      UPDATE: begin
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
        end else begin
          idx_d  = idx_q + 4'd1;
          upd_en = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    for (int j = 0; j < JOINTS; j++)
      if (upd_en && upd_j == 4'(j)) duty_d[j] = ramp_duty(duty_q[j], tgt_d[j]);

    if (accept && joint_ok) wdt_d = '0;
    else if (!fault_q)      wdt_d = wdt_q + WDT_W'(1);
    if (wdt_d == WDT_LAST) fault_d = 1'b1;

    if (fault_d)
      for (int j = 0; j < JOINTS; j++) tgt_d[j] = '0;

    if (!enable) begin
      state_d = IDLE;
      idx_d   = '0;
      wdt_d   = '0;
      fault_d = 1'b0;
      for (int j = 0; j < JOINTS; j++) begin
        tgt_d[j]  = '0;
        duty_d[j] = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      wdt_q   <= '0;
      fault_q <= 1'b0;
      // NOTE: target/duty banks are plain flops driving outputs, so they are reset too.
      for (int j = 0; j < JOINTS; j++) begin
        tgt_q[j]  <= '0;
        duty_q[j] <= '0;
      end
    end else begin
      // NOTE: state updates use non-blocking assignment; the comb block above uses blocking.
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      wdt_q   <= wdt_d;
      fault_q <= fault_d;
      for (int j = 0; j < JOINTS; j++) begin
        tgt_q[j]  <= tgt_d[j];
        duty_q[j] <= duty_d[j];
      end
    end
  end

endmodule

// File: tb/tb_joint_pwm_ramp_ctrl.sv
// Bench for joint_pwm_ramp_ctrl: per-joint queues of expected duty values, popped and
// compared (value and sweep slot) whenever a duty output changes.
module tb_joint_pwm_ramp_ctrl;

  localparam int JOINTS = 4;
  localparam int PERIOD = 1000;
  localparam int STEP   = 100;
  localparam int WDT    = 20000;

  logic                 clk;
  logic                 rst_n;
  logic                 enable;
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [3:0]           cmd_joint;
  logic [31:0]          cmd_value;
  logic [32*JOINTS-1:0] duty_cmd;
  logic                 period_tick;
  logic                 busy;
  logic                 fault;

  int n_total = 0;
  int n_bad   = 0;
  int exp_q[JOINTS][$];
  int prev_duty[JOINTS];
  bit mon_en = 1'b0;
  int since_tick = 100;
  int cyc = 0;
  int acc_cyc = 0;
  int mon_cur, mon_exp;

  joint_pwm_ramp_ctrl #(
    .JOINTS(JOINTS), .PWM_PERIOD(PERIOD), .RAMP_STEP(STEP), .WDT_CYCLES(WDT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_joint(cmd_joint), .cmd_value(cmd_value),
    .duty_cmd(duty_cmd), .period_tick(period_tick),
    .busy(busy), .fault(fault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int duty_of(input int j);
    return $signed(duty_cmd[32*j +: 32]);
  endfunction

  // Scoreboard monitor: a change on joint j must land j+1 cycles after the tick
  // and must equal the next queued expectation for that joint.
  always @(negedge clk) begin
    if (period_tick) since_tick = 0;
    else if (since_tick < 1000000) since_tick++;
    for (int j = 0; j < JOINTS; j++) begin
      mon_cur = duty_of(j);
      if (mon_en && rst_n && mon_cur != prev_duty[j]) begin
        n_total++;
        if (since_tick != j + 1) begin
          n_bad++;
          $display("FAIL slot_j%0d got=%0d exp=%0d cycles after tick", j, since_tick, j + 1);
        end
        n_total++;
        if (exp_q[j].size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_change_j%0d got=%0d exp=%0d (no change)", j, mon_cur, prev_duty[j]);
        end else begin
          mon_exp = exp_q[j].pop_front();
          if (mon_cur !== mon_exp) begin
            n_bad++;
            $display("FAIL duty_j%0d got=%0d exp=%0d", j, mon_cur, mon_exp);
          end
        end
      end
      prev_duty[j] = mon_cur;
    end
  end

  initial begin
    #1500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic wait_tick();
    int k = 0;
    @(negedge clk);
    while (!period_tick && k < 2 * PERIOD) begin
      @(negedge clk);
      k++;
    end
    n_total++;
    if (period_tick !== 1'b1) begin
      n_bad++;
      $display("FAIL tick_timeout got=%0b exp=1", period_tick);
    end
  endtask

  task automatic settle(input int n);
    repeat (n) wait_tick();
    repeat (JOINTS + 2) @(negedge clk);
  endtask

  task automatic send_cmd(input int j, input int v);
    int k = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_joint = 4'(j);
    cmd_value = v;
    while (!cmd_ready && k < 3 * PERIOD) begin
      @(negedge clk);
      k++;
    end
    n_total++;
    if (cmd_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL send_ready_j%0d got=%0b exp=1", j, cmd_ready);
    end
    @(posedge clk);
    #1;
    acc_cyc   = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic check_done(input string name);
    for (int j = 0; j < JOINTS; j++) begin
      n_total++;
      if (exp_q[j].size() != 0) begin
        n_bad++;
        $display("FAIL %s_pending_j%0d got=%0d exp=0 outstanding", name, j, exp_q[j].size());
      end
      exp_q[j].delete();
    end
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < JOINTS; j++) exp_q[j].delete();
    @(negedge clk);
    mon_en = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; enable = 1'b1; cmd_valid = 1'b0; cmd_joint = '0; cmd_value = '0;
    #1;
    n_total++; if (duty_cmd !== '0) begin n_bad++; $display("FAIL reset_duty got=%h exp=0", duty_cmd); end
    n_total++; if (period_tick !== 1'b0) begin n_bad++; $display("FAIL reset_tick got=%b exp=0", period_tick); end
    n_total++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_total++; if (fault !== 1'b0) begin n_bad++; $display("FAIL reset_fault got=%b exp=0", fault); end
    n_total++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got=%b exp=1", cmd_ready); end
    do_reset();
  endtask

  task automatic test_ramp();
    do_reset();
    send_cmd(1, 350);
    exp_q[1] = '{100, 200, 300, 350};
    settle(5);
    check_done("ramp");
    n_total++; if (duty_of(1) != 350) begin n_bad++; $display("FAIL ramp_final got=%0d exp=350", duty_of(1)); end
  endtask

  task automatic test_reversal();
    do_reset();
    send_cmd(2, 150);
    exp_q[2] = '{100, 150};
    settle(3);
    send_cmd(2, -200);
    exp_q[2] = '{50, 0, -100, -200};
    settle(5);
    check_done("reversal");
    n_total++; if (duty_of(2) != -200) begin n_bad++; $display("FAIL reversal_final got=%0d exp=-200", duty_of(2)); end
  endtask

  task automatic test_clamp();
    do_reset();
    send_cmd(0, 5000);
    for (int v = 100; v <= 1000; v += STEP) exp_q[0].push_back(v);
    settle(11);
    check_done("clamp_pos");
    n_total++; if (duty_of(0) != 1000) begin n_bad++; $display("FAIL clamp_pos_final got=%0d exp=1000", duty_of(0)); end
    send_cmd(0, -5000);
    for (int v = 900; v >= -1000; v -= STEP) exp_q[0].push_back(v);
    settle(10);
    send_cmd(3, 0);
    settle(11);
    check_done("clamp_neg");
    n_total++; if (duty_of(0) != -1000) begin n_bad++; $display("FAIL clamp_neg_final got=%0d exp=-1000", duty_of(0)); end
  endtask

  task automatic test_handshake();
    int low = 0;
    int k = 0;
    do_reset();
    wait_tick();
    n_total++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL hs_ready_tick got=%b exp=1", cmd_ready); end
    exp_q[0].push_back(50);
    exp_q[1].push_back(100);
    cmd_valid = 1'b1; cmd_joint = 4'd0; cmd_value = 50;
    @(posedge clk);
    #1;
    cmd_joint = 4'd1; cmd_value = 100;
    @(negedge clk);
    while (!cmd_ready && k < 20) begin
      n_total++; if (busy !== 1'b1) begin n_bad++; $display("FAIL hs_busy_hi got=%b exp=1", busy); end
      low++; k++;
      @(negedge clk);
    end
    n_total++; if (low != JOINTS) begin n_bad++; $display("FAIL hs_low_cycles got=%0d exp=%0d", low, JOINTS); end
    n_total++; if (busy !== 1'b0) begin n_bad++; $display("FAIL hs_busy_lo got=%b exp=0", busy); end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    settle(2);
    check_done("handshake");
  endtask

  task automatic test_watchdog();
    int t0;
    int k = 0;
    do_reset();
    send_cmd(3, 300);
    t0 = acc_cyc;
    exp_q[3] = '{100, 200, 300};
    settle(3);
    send_cmd(7, 500);
    exp_q[3].push_back(200); exp_q[3].push_back(100); exp_q[3].push_back(0);
    while (!fault && k < WDT + 5000) begin
      @(negedge clk);
      k++;
    end
    n_total++; if (fault !== 1'b1) begin n_bad++; $display("FAIL wdt_fault got=%b exp=1", fault); end
    n_total++; if (cyc - t0 != WDT - 1) begin n_bad++; $display("FAIL wdt_latency got=%0d exp=%0d", cyc - t0, WDT - 1); end
    n_total++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL wdt_ready got=%b exp=0", cmd_ready); end
    settle(4);
    check_done("watchdog");
    n_total++; if (duty_of(3) != 0) begin n_bad++; $display("FAIL wdt_duty3 got=%0d exp=0", duty_of(3)); end
    enable = 1'b0;
    @(negedge clk);
    n_total++; if (fault !== 1'b0) begin n_bad++; $display("FAIL wdt_clear got=%b exp=0", fault); end
    n_total++; if (duty_cmd !== '0) begin n_bad++; $display("FAIL wdt_duty_all got=%h exp=0", duty_cmd); end
    enable = 1'b1;
    #1;
    n_total++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL wdt_ready_back got=%b exp=1", cmd_ready); end
  endtask

  task automatic setup_two();
    send_cmd(0, 100);
    send_cmd(3, 100);
    exp_q[0].push_back(100);
    exp_q[3].push_back(100);
    settle(2);
    check_done("midsweep_setup");
    wait_tick();
    repeat (3) @(negedge clk);
    n_total++; if (busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy got=%b exp=1", busy); end
  endtask

  task automatic test_midsweep();
    do_reset();
    setup_two();
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    n_total++; if (duty_cmd !== '0) begin n_bad++; $display("FAIL arst_duty got=%h exp=0", duty_cmd); end
    n_total++; if (busy !== 1'b0) begin n_bad++; $display("FAIL arst_busy got=%b exp=0", busy); end
    n_total++; if (period_tick !== 1'b0) begin n_bad++; $display("FAIL arst_tick got=%b exp=0", period_tick); end
    n_total++; if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL arst_ready got=%b exp=1", cmd_ready); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
    setup_two();
    mon_en = 1'b0;
    enable = 1'b0;
    @(posedge clk);
    #1;
    n_total++; if (busy !== 1'b0) begin n_bad++; $display("FAIL en_busy got=%b exp=0", busy); end
    n_total++; if (duty_cmd !== '0) begin n_bad++; $display("FAIL en_duty got=%h exp=0", duty_cmd); end
    n_total++; if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL en_ready got=%b exp=0", cmd_ready); end
    wait_tick();
    n_total++; if (duty_cmd !== '0) begin n_bad++; $display("FAIL en_hold got=%h exp=0", duty_cmd); end
    enable = 1'b1;
    repeat (2) @(negedge clk);
    mon_en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_reversal();
    test_clamp();
    test_handshake();
    test_watchdog();
    test_midsweep();
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/joint_pwm_ramp_ctrl.md
# joint_pwm_ramp_ctrl

Sequencer and slew limiter for a bank of PWM/DIR joint drivers. Accepts per-joint signed duty targets over a valid/ready command port. Once per PWM period it walks every joint and moves each registered duty command toward its target by at most one ramp step, passing through zero on direction reversal. Its outputs drive the `jointFreqCmd` inputs of the per-joint PWM/DIR generators. It also owns the command watchdog and the global enable.

## Interface
- `JOINTS`, 4, number of joint channels (1..16; must be ≤ `PWM_PERIOD`)
- `PWM_PERIOD`, 100000, clk cycles per PWM period; also the duty magnitude clamp
- `RAMP_STEP`, 100, maximum per-period change of a joint's duty command (≥1)
- `WDT_CYCLES`, 5000000, clk cycles without an accepted command before fault
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous active-low reset
- `enable`  in  1  global enable; low forces all duties to 0 and clears fault
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  command can be accepted this cycle
- `cmd_joint`  in  4  target joint index
- `cmd_value`  in  32  signed duty target
- `duty_cmd`  out  32*JOINTS  signed registered duty per joint, joint j at bits [32j+31:32j]
- `period_tick`  out  1  one-cycle pulse on the last cycle of each period
- `busy`  out  1  high while the update sweep runs
- `fault`  out  1  watchdog fault, sticky

## Operation
- Reset values: `duty_cmd` all 0, all targets 0, period counter 0, `period_tick` 0, `busy` 0, `fault` 0, `cmd_ready` 1, FSM in IDLE.
- Period counter counts 0..`PWM_PERIOD`-1, then wraps. It runs regardless of `enable`.
- `period_tick` is registered. It is high for the cycle in which the counter equals `PWM_PERIOD`-1.
- A command is accepted when `cmd_valid` && `cmd_ready`.
  - On accept, the target for joint `cmd_joint` is loaded with `cmd_value` clamped to ±`PWM_PERIOD`.
  - If `cmd_joint` ≥ `JOINTS`, the command is accepted and discarded. It does not kick the watchdog.
- `cmd_ready` = IDLE && `enable` && !`fault`. When it is low, the command is not consumed.
- FSM IDLE: on `period_tick`, go to UPDATE with idx=0 and set `busy`=1.
- FSM UPDATE: process one joint per cycle at index idx; idx++. After idx=`JOINTS`-1, return to IDLE and clear `busy`.
- Per-joint update, with c = current duty and t = target:
  - If c and t have opposite signs (both nonzero): c moves toward 0 by `RAMP_STEP`. If |c| ≤ `RAMP_STEP`, c becomes exactly 0. A zero crossing never happens within one step.
  - Otherwise, if |t−c| ≤ `RAMP_STEP`, c = t. Else c moves toward t by `RAMP_STEP`.
  - As a result, a reversal always holds 0 for at least one full period.
- Arithmetic is 33-bit signed internally. Clamping is done before subtraction, so no overflow is possible.
- Watchdog counter:
  - Increments each cycle while `enable` && !`fault`.
  - Cleared by a valid accepted command and by `enable` low.
  - When it reaches `WDT_CYCLES`-1, `fault` is set.
  - While `fault`=1, all targets are forced to 0 and duties ramp down normally.
- `enable` low, synchronous:
  - Next edge: all targets 0, all `duty_cmd` 0, `fault` 0, watchdog 0.
  - An in-progress sweep is aborted to IDLE and `busy` goes to 0.
- Asynchronous reset mid-sweep returns all outputs to their reset values immediately.

## Timing
- Joint j's `duty_cmd` changes on the clock edge j+1 cycles after the edge that raised `period_tick`.
- Command-to-effect latency: the target is written at the accept edge. It is first applied at the next sweep reaching that joint. If accepted during the tick cycle, it applies in that same sweep.
- `cmd_ready` falls the edge after the tick and rises the edge after the last joint update (`JOINTS` cycles low).
- Simultaneous accept and sweep cannot occur, because `cmd_ready` is low during UPDATE.
- `fault` asserts on the edge at which the watchdog count reaches `WDT_CYCLES`-1. Target forcing takes effect from the same edge.

## Test plan
Use `JOINTS`=4, `PWM_PERIOD`=1000, `RAMP_STEP`=100, `WDT_CYCLES`=20000, `enable`=1.
- Ramp: joint1 ← 350 → duty1 reads 100, 200, 300, 350 over four sweeps, then holds; other joints stay 0. Each change lands exactly 2 cycles after `period_tick`.
- Reversal: joint2 settled at 150, then ← −200 → duty2 reads 50, 0, −100, −200; it is never positive after 50.
- Clamp and bad index:
  - joint0 ← 5000 → settles at 1000.
  - joint0 ← −5000 → settles at −1000.
  - `cmd_joint`=7 → accepted, no duty change, and the watchdog is not cleared.
- Handshake: hold `cmd_valid` from the tick cycle +1 → `cmd_ready` is low for exactly 4 cycles, and the command is accepted on the first IDLE cycle.
- Watchdog: joint3 ← 300, then no commands for 20000 cycles → `fault`=1, `cmd_ready`=0, and duty3 ramps 200, 100, 0. Then `enable`=0 for 1 cycle → `fault`=0 and all duties 0.
- Reset/enable mid-sweep:
  - Assert `rst_n`=0 at idx=2 → all outputs return to reset values without waiting for a clock edge.
  - Repeat with `enable`=0 → `busy`=0 and duties 0 on the next edge.
